// File: rtl/hart_mem_arbiter_pkg.sv
// Shared definitions for the HART memory-port arbiter: FSM state encodings,
// grant identifiers and the fixed access code used for instruction fetches.
package hart_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    localparam logic [2:0] F3_WORD = 3'b010;

endpackage

// File: rtl/hart_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick. Bit 0 of req is the instruction port and bit 1 the
// data port. On a tie the requester that was not served last wins. Kept
// separate so multi-HART bus arbitration can reuse the same pick.
module rr_arbiter2
    import hart_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    // Combinational pick: single requester wins outright, a tie alternates.
    always_comb begin
        valid = |req;
        grant = GRANT_IC;
        case (req)
            2'b01:   grant = GRANT_IC;
            2'b10:   grant = GRANT_DM;
            2'b11:   grant = (last_grant == GRANT_IC) ? GRANT_DM : GRANT_IC;
            default: grant = GRANT_IC;
        endcase
    end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Shares a single memory bus port between the instruction-fetch and data
// ports of one HART. One transaction at a time: the winning request is
// latched, driven onto the bus until the bus answers, and the reply is
// returned to the requester with a one-cycle ready pulse. All outputs are
// registered, so no input reaches an output combinationally.
module hart_mem_arbiter
    import hart_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_IC_DataReq,
    input  logic [ADDR_WIDTH-1:0] i_IC_Addr,
    output logic                  o_IC_MemReady,
    output logic [DATA_WIDTH-1:0] o_IC_Instr,
    input  logic                  i_DM_MemRead,
    input  logic                  i_DM_Wen,
    input  logic [ADDR_WIDTH-1:0] i_DM_Addr,
    input  logic [DATA_WIDTH-1:0] i_DM_WriteData,
    input  logic [2:0]            i_DM_f3,
    output logic                  o_DM_data_ready,
    output logic [DATA_WIDTH-1:0] o_DM_ReadData,
    output logic                  o_MEM_Req,
    output logic                  o_MEM_Wen,
    output logic [ADDR_WIDTH-1:0] o_MEM_Addr,
    output logic [DATA_WIDTH-1:0] o_MEM_WriteData,
    output logic [2:0]            o_MEM_f3,
    input  logic                  i_MEM_ready,
    input  logic [DATA_WIDTH-1:0] i_MEM_ReadData
);

    arb_state_t state;
    arb_state_t next_state;
    logic       last_grant;
    logic [1:0] req;
    logic       arb_valid;
    logic       arb_grant;

    // A data request is either a read or a write; bit 1 is the data port.
    assign req = {i_DM_MemRead | i_DM_Wen, i_IC_DataReq};

    rr_arbiter2 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: grant from IDLE, wait for the bus, then one response cycle.
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: begin
                if (arb_valid) begin
                    next_state = (arb_grant == GRANT_DM) ? ARB_DBUSY : ARB_IBUSY;
                end
            end
            ARB_IBUSY, ARB_DBUSY: begin
                if (i_MEM_ready) begin
                    next_state = ARB_RESP;
                end
            end
            ARB_RESP: next_state = ARB_IDLE;
            default:  next_state = ARB_IDLE;
        endcase
    end

    // Registered bus fields, response data and ready pulses. Bus fields are
    // latched once at grant so live requester inputs cannot disturb them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant      <= GRANT_IC;
            o_MEM_Req       <= 1'b0;
            o_MEM_Wen       <= 1'b0;
            o_MEM_Addr      <= '0;
            o_MEM_WriteData <= '0;
            o_MEM_f3        <= 3'b000;
            o_IC_MemReady   <= 1'b0;
            o_IC_Instr      <= '0;
            o_DM_data_ready <= 1'b0;
            o_DM_ReadData   <= '0;
        end else begin
            o_IC_MemReady   <= 1'b0;
            o_DM_data_ready <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (arb_valid) begin
                        o_MEM_Req <= 1'b1;
                        if (arb_grant == GRANT_DM) begin
                            o_MEM_Wen       <= i_DM_Wen;
                            o_MEM_Addr      <= i_DM_Addr;
                            o_MEM_WriteData <= i_DM_WriteData;
                            o_MEM_f3        <= i_DM_f3;
                        end else begin
                            o_MEM_Wen       <= 1'b0;
                            o_MEM_Addr      <= i_IC_Addr;
                            o_MEM_WriteData <= '0;
                            o_MEM_f3        <= F3_WORD;
                        end
                    end
                end
                ARB_IBUSY: begin
                    if (i_MEM_ready) begin
                        o_MEM_Req     <= 1'b0;
                        o_IC_Instr    <= i_MEM_ReadData;
                        o_IC_MemReady <= 1'b1;
                        last_grant    <= GRANT_IC;
                    end
                end
                ARB_DBUSY: begin
                    if (i_MEM_ready) begin
                        o_MEM_Req       <= 1'b0;
                        o_DM_ReadData   <= i_MEM_ReadData;
                        o_DM_data_ready <= 1'b1;
                        last_grant      <= GRANT_DM;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/hart_mem_arbiter.md
Name: hart_mem_arbiter

Overview:
- Shares one memory bus port between the instruction-fetch and data-access ports of a single HART.
- Sits between the HART and the memory/bus interconnect, so the core needs only one memory port.
- Serves one transaction at a time: it latches the request, drives the memory bus, and returns the response to the requester with a one-cycle ready pulse.
- On simultaneous requests, arbitration is round-robin.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_IC_DataReq  input  1  instruction fetch request, held until o_IC_MemReady.
- i_IC_Addr  input  ADDR_WIDTH  fetch address.
- o_IC_MemReady  output  1  one-cycle pulse: o_IC_Instr is valid.
- o_IC_Instr  output  DATA_WIDTH  fetched instruction, held until the next IC response.
- i_DM_MemRead  input  1  data read request, held until o_DM_data_ready.
- i_DM_Wen  input  1  data write request, held until o_DM_data_ready.
- i_DM_Addr  input  ADDR_WIDTH  data address.
- i_DM_WriteData  input  DATA_WIDTH  store data.
- i_DM_f3  input  3  access size/sign code (funct3).
- o_DM_data_ready  output  1  one-cycle pulse: data access complete.
- o_DM_ReadData  output  DATA_WIDTH  load data, held until the next DM response.
- o_MEM_Req  output  1  bus request, held until i_MEM_ready.
- o_MEM_Wen  output  1  bus write enable.
- o_MEM_Addr  output  ADDR_WIDTH  bus address.
- o_MEM_WriteData  output  DATA_WIDTH  bus store data.
- o_MEM_f3  output  3  bus access code.
- i_MEM_ready  input  1  bus completion, one cycle.
- i_MEM_ReadData  input  DATA_WIDTH  bus read data, valid when i_MEM_ready=1.

Behaviour:
- States:
  - IDLE: no transaction in progress.
  - IBUSY: instruction fetch on the bus.
  - DBUSY: data access on the bus.
  - RESP: one cycle in which the ready pulse is driven.
- Request definitions:
  - DM request = i_DM_MemRead | i_DM_Wen.
  - If both are set, the access is a write (o_MEM_Wen=1).
- IDLE with exactly one request: latch that requester's addr/data/f3/wen and go to IBUSY or DBUSY.
- IDLE with both requests: grant the requester not served last (last_grant register); the loser keeps waiting.
- Bus fields for a fetch: o_MEM_Wen=0, o_MEM_f3=3'b010, o_MEM_WriteData=0.
- IBUSY/DBUSY:
  - o_MEM_Req=1 and all o_MEM_* outputs are stable from the latched registers. They do not follow live inputs.
  - On i_MEM_ready=1: capture i_MEM_ReadData into the granted requester's data register, update last_grant, and go to RESP.
- RESP:
  - Pulse the granted requester's ready for exactly one cycle; o_MEM_Req=0.
  - Requests are ignored this cycle, because the requester is still asserting the request it just had answered.
  - Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 → o_MEM_Req=1 from cycle 1.
  - i_MEM_ready at cycle k → requester ready at cycle k+1 → IDLE at cycle k+2.
  - Minimum round trip is 3 cycles with a zero-wait bus (ready at cycle 1).
- All outputs are registered. No combinational path from any input to any output.
- A requester that drops its request while waiting is not served. A request dropped after grant is still completed on the bus, but its ready pulse is discarded by the requester.
- i_MEM_ready outside IBUSY/DBUSY is ignored.
- Reset:
  - Applies in any state, including mid-transaction. Next state is IDLE.
  - All outputs go to 0, including data registers and o_MEM_*.
  - last_grant resets to IC, so the first tie goes to DM.
  - An abandoned bus transaction is dropped; the bus must tolerate o_MEM_Req falling before ready.
- Write responses: o_DM_ReadData is updated with whatever i_MEM_ReadData shows; its value is don't-care for the core.

Decomposition:
- Shared defines (codebase defines header):
  - state encodings ARB_IDLE, ARB_IBUSY, ARB_DBUSY, ARB_RESP;
  - GRANT_IC/GRANT_DM;
  - F3_WORD=3'b010.
- No sub-module needed.
- A small rr_arbiter2 (2-way round-robin pick from req[1:0] and last_grant) may be factored out for reuse by multi-HART bus arbitration.

Test Plan:
- Single fetch, addr 0x0000_0100, bus ready at cycle 2 with data 0x0000_0013 → o_MEM_Req cycles 1–2, o_MEM_Addr=0x100, o_MEM_f3=3'b010, o_IC_MemReady pulse at cycle 3 with o_IC_Instr=0x13, IDLE at cycle 4.
- Store: addr 0x2000, data 0xDEADBEEF, f3=3'b010, zero-wait bus → o_MEM_Wen=1, o_MEM_WriteData=0xDEADBEEF during the request, o_DM_data_ready one pulse, o_IC_MemReady stays 0.
- IC and DM both request from reset, each held → DM served first, then IC; a second tie afterwards is served IC then DM (alternation).
- Held request after response: IC request held through RESP → no second bus transaction starts in the RESP cycle; a new one starts only from IDLE.
- Reset asserted during DBUSY with no bus ready → next cycle o_MEM_Req=0, all outputs 0; a later i_MEM_ready produces no ready pulse.
- Bus wait states: i_MEM_ready delayed 5 cycles while i_DM_Addr changes mid-request → o_MEM_Addr stays at the latched value; the response arrives at k+1.
